// File: rtl/fetch_stage_latch_pkg.sv
// Shared types for the fetch-stage latch: path widths, FSM state and per-lane prediction.
// The optional stall-cycle counter is enabled with RSD_FETCH_STALL_COUNTER_EN.
package fetch_stage_latch_pkg;

  localparam int FETCH_WIDTH     = 2;
  localparam int PC_PATH_WIDTH   = 32;
  localparam int OP_SERIAL_WIDTH = 10;

  typedef logic [PC_PATH_WIDTH-1:0]   pc_path_t;
  typedef logic [OP_SERIAL_WIDTH-1:0] op_serial_t;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    STALL_FIRST = 2'd1,
    STALL_HOLD  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic     btb_hit;
    logic     pred_taken;
    pc_path_t target;
  } fetch_pred_t;

endpackage

// File: rtl/fetch_stage_latch_if.sv
// Controller/next-PC/predictor bundle for the fetch-stage latch; master drives, slave is the latch.
interface fetch_stage_latch_if #(
  parameter int FETCH_WIDTH     = fetch_stage_latch_pkg::FETCH_WIDTH,
  parameter int STALL_CNT_WIDTH = 32
);
  import fetch_stage_latch_pkg::*;

  // No backpressure: a lane is valid while outValid is set; stall holds lanes, clear drops valid.
  logic                                         stall;
  logic                                         clear;
  logic [FETCH_WIDTH-1:0]                       inValid;
  logic [FETCH_WIDTH-1:0][PC_PATH_WIDTH-1:0]    inPC;
  logic [FETCH_WIDTH-1:0][OP_SERIAL_WIDTH-1:0]  inSID;
  logic [FETCH_WIDTH-1:0]                       bpBtbHit;
  logic [FETCH_WIDTH-1:0]                       bpPredTaken;
  logic [FETCH_WIDTH-1:0][PC_PATH_WIDTH-1:0]    bpTarget;
  logic [FETCH_WIDTH-1:0]                       outValid;
  logic [FETCH_WIDTH-1:0][PC_PATH_WIDTH-1:0]    outPC;
  logic [FETCH_WIDTH-1:0][OP_SERIAL_WIDTH-1:0]  outSID;
  logic [FETCH_WIDTH-1:0]                       outBtbHit;
  logic [FETCH_WIDTH-1:0]                       outPredTaken;
  logic [FETCH_WIDTH-1:0][PC_PATH_WIDTH-1:0]    outTarget;
  logic                                         regStall;
  logic [STALL_CNT_WIDTH-1:0]                   stallCycles;

  modport master (
    output stall, clear, inValid, inPC, inSID, bpBtbHit, bpPredTaken, bpTarget,
    input  outValid, outPC, outSID, outBtbHit, outPredTaken, outTarget, regStall, stallCycles
  );

  modport slave (
    input  stall, clear, inValid, inPC, inSID, bpBtbHit, bpPredTaken, bpTarget,
    output outValid, outPC, outSID, outBtbHit, outPredTaken, outTarget, regStall, stallCycles
  );

endinterface

// File: rtl/fetch_stage_latch_pred_hold_lane.sv
// One lane of prediction capture/hold: passes predictor outputs through while running,
// replays the value captured at stall entry while stalled, and masks flags on invalid lanes.
module fetch_stage_latch_pred_hold_lane
  import fetch_stage_latch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        capture_i,
  input  logic        use_hold_i,
  input  logic        lane_valid_i,
  input  fetch_pred_t bp_i,
  output fetch_pred_t pred_o
);

  fetch_pred_t hold_q, hold_d, sel;

  always_comb begin
    hold_d = hold_q;
    if (capture_i) hold_d = bp_i;
  end

  always_ff @(posedge clk) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end

  // The predictor SRAM is re-addressed during a stall, so only the held copy is trustworthy.
  always_comb begin
    sel               = use_hold_i ? hold_q : bp_i;
    pred_o            = sel;
    pred_o.btb_hit    = sel.btb_hit & lane_valid_i;
    pred_o.pred_taken = sel.pred_taken & lane_valid_i;
  end

endmodule

// File: rtl/fetch_stage_latch.sv
// Fetch-stage pipeline latch with stall/flush control and prediction hold across stalls.
// Define RSD_FETCH_STALL_COUNTER_EN to build the saturating stall-cycle counter.
module fetch_stage_latch
  import fetch_stage_latch_pkg::*;
#(
  parameter int FETCH_WIDTH     = fetch_stage_latch_pkg::FETCH_WIDTH,
  parameter int STALL_CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_stage_latch_if.slave    bus,
  output fetch_state_e          state_o
);

  fetch_state_e state_q, state_d;
  logic         capture, use_hold;

  logic [FETCH_WIDTH-1:0]                      valid_q, valid_d;
  logic [FETCH_WIDTH-1:0][PC_PATH_WIDTH-1:0]   pc_q, pc_d;
  logic [FETCH_WIDTH-1:0][OP_SERIAL_WIDTH-1:0] sid_q, sid_d;
  logic                                        reg_stall_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Flush wins over stall and always returns to RUN.
  always_comb begin
    state_d = state_q;
    if (bus.clear || !bus.stall) state_d = RUN;
    else if (state_q == RUN)     state_d = STALL_FIRST;
    else                         state_d = STALL_HOLD;
  end

  always_comb begin
    capture  = (state_q == RUN) && bus.stall && !bus.clear;
    use_hold = (state_q != RUN);
  end

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    sid_d   = sid_q;
    if (bus.clear) begin
      valid_d = '0;
    end else if (!bus.stall) begin
      valid_d = bus.inValid;
      pc_d    = bus.inPC;
      sid_d   = bus.inSID;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      reg_stall_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      reg_stall_q <= bus.stall;
    end
  end

  // PC and serial are only meaningful under a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    pc_q  <= pc_d;
    sid_q <= sid_d;
  end

  for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_lane
    fetch_pred_t bp_in, pred_out;

    assign bp_in = '{btb_hit: bus.bpBtbHit[i], pred_taken: bus.bpPredTaken[i], target: bus.bpTarget[i]};

    fetch_stage_latch_pred_hold_lane u_hold (
      .clk          (clk),
      .rst          (rst),
      .capture_i    (capture),
      .use_hold_i   (use_hold),
      .lane_valid_i (valid_q[i]),
      .bp_i         (bp_in),
      .pred_o       (pred_out)
    );

    assign bus.outBtbHit[i]    = pred_out.btb_hit;
    assign bus.outPredTaken[i] = pred_out.pred_taken;
    assign bus.outTarget[i]    = pred_out.target;
  end

`ifdef RSD_FETCH_STALL_COUNTER_EN
  logic [STALL_CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q != RUN && cnt_q != '1) cnt_d = cnt_q + STALL_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bus.stallCycles = cnt_q;
`else
  assign bus.stallCycles = '0;
`endif

  assign bus.outValid = valid_q;
  assign bus.outPC    = pc_q;
  assign bus.outSID   = sid_q;
  assign bus.regStall = reg_stall_q;
  assign state_o      = state_q;

endmodule
